// File: rtl/aes_pkg.sv
// Constants and state encoding shared by the AES key sequencer and its slot register file.
package aes_pkg;

    localparam int AES_KEY_W = 256;
    localparam int AES_BLK_W = 128;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_ENC    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_key_slot_ram.sv
// Key slot register file: one write port, one asynchronous read port, every slot
// returns to the default key and keylen on reset.
module aes_key_slot_ram
    import aes_pkg::*;
#(
    parameter int                   NUM_SLOTS      = 4,
    parameter int                   SLOT_W         = 2,
    parameter logic [AES_KEY_W-1:0] DEFAULT_KEY    = '0,
    parameter logic                 DEFAULT_KEYLEN = KEYLEN_128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic [SLOT_W-1:0]    wr_slot_i,
    input  logic [AES_KEY_W-1:0] wr_key_i,
    input  logic                 wr_len_i,
    input  logic [SLOT_W-1:0]    rd_slot_i,
    output logic [AES_KEY_W-1:0] rd_key_o,
    output logic                 rd_len_o
);

    // Bit AES_KEY_W holds the keylen, the rest holds the key.
    logic [AES_KEY_W:0] slot_q [NUM_SLOTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= {DEFAULT_KEYLEN, DEFAULT_KEY};
            end
        end else if (wr_en_i && (int'(wr_slot_i) < NUM_SLOTS)) begin
            slot_q[wr_slot_i] <= {wr_len_i, wr_key_i};
        end
    end

    assign {rd_len_o, rd_key_o} = slot_q[rd_slot_i];

endmodule

// File: rtl/aes_key_sequencer.sv
// Key management and start gating between the comm block and aes_core: selects the
// active key slot, sequences key expansion, and optionally rotates slots.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_INIT   | aes_init pulses for one cycle with the active slot's key
// ST_EXPAND | aes_core expanding the key; waiting for aes_ready
// ST_READY  | key expanded; encryptions, slot changes and rekeys accepted
// ST_ENC    | aes_core encrypting; waiting for aes_ready
module aes_key_sequencer
    import aes_pkg::*;
#(
    parameter int                   NUM_SLOTS      = 4,
    parameter int                   SLOT_W         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter logic [AES_KEY_W-1:0] DEFAULT_KEY    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
    parameter logic                 DEFAULT_KEYLEN = KEYLEN_128,
    parameter int                   REKEY_INTERVAL = 0,
    parameter int                   CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_wr_valid,
    output logic                 key_wr_ready,
    input  logic [SLOT_W-1:0]    key_wr_slot,
    input  logic [AES_KEY_W-1:0] key_wr_data,
    input  logic                 key_wr_len,
    input  logic                 key_sel_valid,
    output logic                 key_sel_ready,
    input  logic [SLOT_W-1:0]    key_sel,
    input  logic                 enc_start,
    input  logic                 aes_ready,
    output logic                 aes_init,
    output logic                 aes_next,
    output logic [AES_KEY_W-1:0] aes_key,
    output logic                 aes_keylen,
    output logic                 key_ready,
    output logic [SLOT_W-1:0]    active_slot,
    output logic [CNT_W-1:0]     enc_count,
    output logic                 req_overrun
);

    seq_state_e         state_q, state_d;
    logic [SLOT_W-1:0]  active_slot_q, active_slot_d;
    logic               key_ready_q, key_ready_d;
    logic [CNT_W-1:0]   enc_count_q, enc_count_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               aes_init_q, aes_init_d;
    logic               first_q, first_d;

    logic               fire;
    logic               wr_accept;
    logic               sel_change;
    logic               wr_active;
    logic [CNT_W-1:0]   count_inc;
    logic [SLOT_W-1:0]  next_slot;

    aes_key_slot_ram #(
        .NUM_SLOTS      (NUM_SLOTS),
        .SLOT_W         (SLOT_W),
        .DEFAULT_KEY    (DEFAULT_KEY),
        .DEFAULT_KEYLEN (DEFAULT_KEYLEN)
    ) u_slot_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_accept),
        .wr_slot_i (key_wr_slot),
        .wr_key_i  (key_wr_data),
        .wr_len_i  (key_wr_len),
        .rd_slot_i (active_slot_q),
        .rd_key_o  (aes_key),
        .rd_len_o  (aes_keylen)
    );

    assign fire = (state_q == ST_READY) && (pending_q || enc_start) && aes_ready;

    // The active slot's key must not move under aes_core outside READY, nor in
    // the cycle an encryption is launched.
    assign key_wr_ready  = !reset && !((key_wr_slot == active_slot_q) &&
                                       ((state_q != ST_READY) || fire));
    assign key_sel_ready = (state_q == ST_READY) && !pending_q && !enc_start;
    assign wr_accept     = key_wr_valid && key_wr_ready;

    assign sel_change = key_sel_valid && key_sel_ready && (key_sel != active_slot_q) &&
                        (int'(key_sel) < NUM_SLOTS);
    assign wr_active  = wr_accept && (key_wr_slot == active_slot_q) && (state_q == ST_READY);

    assign count_inc = (enc_count_q == '1) ? enc_count_q : enc_count_q + 1'b1;
    assign next_slot = (int'(active_slot_q) == NUM_SLOTS - 1) ? '0 : active_slot_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        active_slot_d = active_slot_q;
        key_ready_d   = key_ready_q;
        enc_count_d   = enc_count_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;

        case (state_q)
            ST_INIT: begin
                // Straight out of reset aes_init is still low; stay one more cycle to pulse it.
                if (aes_init_q) begin
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (!first_q && aes_ready) begin
                    key_ready_d = 1'b1;
                    enc_count_d = '0;
                    state_d     = ST_READY;
                end
            end
            ST_READY: begin
                if (fire) begin
                    state_d = ST_ENC;
                end else if (sel_change) begin
                    active_slot_d = key_sel;
                    key_ready_d   = 1'b0;
                    state_d       = ST_INIT;
                end else if (wr_active) begin
                    key_ready_d = 1'b0;
                    state_d     = ST_INIT;
                end
            end
            ST_ENC: begin
                if (!first_q && aes_ready) begin
                    enc_count_d = count_inc;
                    if ((REKEY_INTERVAL != 0) && (count_inc == CNT_W'(REKEY_INTERVAL))) begin
                        active_slot_d = next_slot;
                        key_ready_d   = 1'b0;
                        state_d       = ST_INIT;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (fire) begin
            pending_d = 1'b0;
        end
        if (enc_start) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else if (!fire) begin
                pending_d = 1'b1;
            end
        end
    end

    assign aes_init_d = (state_d == ST_INIT);
    assign first_d    = (state_d != state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            active_slot_q <= '0;
            key_ready_q   <= 1'b0;
            enc_count_q   <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            aes_init_q    <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_slot_q <= active_slot_d;
            key_ready_q   <= key_ready_d;
            enc_count_q   <= enc_count_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            aes_init_q    <= aes_init_d;
            first_q       <= first_d;
        end
    end

    assign aes_init    = aes_init_q;
    assign aes_next    = fire;
    assign key_ready   = key_ready_q;
    assign active_slot = active_slot_q;
    assign enc_count   = enc_count_q;
    assign req_overrun = overrun_q;

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Bench for aes_key_sequencer: an aes_core latency model drives aes_ready, and a
// scoreboard checks every aes_init / aes_next pulse against expected key, slot and count.
module tb_aes_key_sequencer;
    import aes_pkg::*;

    localparam int LAT = 4;
    localparam logic [255:0] DEF_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk, reset;
    logic         key_wr_valid, key_wr_ready, key_wr_len;
    logic [1:0]   key_wr_slot;
    logic [255:0] key_wr_data;
    logic         key_sel_valid, key_sel_ready;
    logic [1:0]   key_sel;
    logic         enc_start, aes_ready, aes_init, aes_next, aes_keylen, key_ready, req_overrun;
    logic [255:0] aes_key;
    logic [1:0]   active_slot;
    logic [15:0]  enc_count;

    typedef struct {
        logic         is_next;
        logic [255:0] key;
        logic         len;
        logic [1:0]   slot;
        logic [15:0]  cnt;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_cnt = 0;
    int   busy = 0;
    logic hold_low;
    logic seen;

    aes_key_sequencer #(
        .NUM_SLOTS      (4),
        .REKEY_INTERVAL (3),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_wr_valid  (key_wr_valid),
        .key_wr_ready  (key_wr_ready),
        .key_wr_slot   (key_wr_slot),
        .key_wr_data   (key_wr_data),
        .key_wr_len    (key_wr_len),
        .key_sel_valid (key_sel_valid),
        .key_sel_ready (key_sel_ready),
        .key_sel       (key_sel),
        .enc_start     (enc_start),
        .aes_ready     (aes_ready),
        .aes_init      (aes_init),
        .aes_next      (aes_next),
        .aes_key       (aes_key),
        .aes_keylen    (aes_keylen),
        .key_ready     (key_ready),
        .active_slot   (active_slot),
        .enc_count     (enc_count),
        .req_overrun   (req_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t mk_ev(input logic is_next, input logic [255:0] key, input logic len,
                                  input logic [1:0] slot, input logic [15:0] cnt);
        ev_t e;
        e.is_next = is_next;
        e.key     = key;
        e.len     = len;
        e.slot    = slot;
        e.cnt     = cnt;
        return e;
    endfunction

    // aes_core model: busy for LAT cycles after each init/next it sees
    initial begin
        aes_ready = 1'b0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2 seen = aes_init | aes_next;
            @(posedge clk);
            #1;
            if (seen) busy = LAT;
            else if (busy > 0) busy = busy - 1;
            aes_ready = (busy == 0) && !hold_low;
        end
    end

    // Scoreboard: pop one expected event per aes_init / aes_next pulse
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            #2;
            if (aes_init === 1'b1 || aes_next === 1'b1) begin
                if (aes_next === 1'b1) next_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got init=%b next=%b slot=%0d required no pulse",
                             aes_init, aes_next, active_slot);
                end else begin
                    ev = exp_q.pop_front();
                    if (aes_next !== ev.is_next || aes_key !== ev.key || aes_keylen !== ev.len ||
                        active_slot !== ev.slot || (ev.is_next && enc_count !== ev.cnt)) begin
                        errors++;
                        $display("FAIL sb_event got next=%b key=%h len=%b slot=%0d cnt=%0d required next=%b key=%h len=%b slot=%0d cnt=%0d",
                                 aes_next, aes_key, aes_keylen, active_slot, enc_count,
                                 ev.is_next, ev.key, ev.len, ev.slot, ev.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (key_sel_ready) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_idle_timeout got key_sel_ready=0 required 1 within 80 cycles", tag);
        end
    endtask

    task automatic test_reset();
        int init_n, rdy_idx, kr_idx;
        reset = 1'b1;
        hold_low = 1'b1;
        key_wr_valid = 1'b0; key_wr_slot = 2'd1; key_wr_data = '0; key_wr_len = 1'b0;
        key_sel_valid = 1'b0; key_sel = 2'd0; enc_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (aes_init !== 1'b0) begin errors++; $display("FAIL rst_aes_init got %b required 0", aes_init); end
        checks++; if (aes_next !== 1'b0) begin errors++; $display("FAIL rst_aes_next got %b required 0", aes_next); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL rst_key_ready got %b required 0", key_ready); end
        checks++; if (active_slot !== 2'd0) begin errors++; $display("FAIL rst_active_slot got %0d required 0", active_slot); end
        checks++; if (enc_count !== 16'd0) begin errors++; $display("FAIL rst_enc_count got %0d required 0", enc_count); end
        checks++; if (req_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b required 0", req_overrun); end
        checks++; if (key_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b required 0", key_wr_ready); end
        checks++; if (key_sel_ready !== 1'b0) begin errors++; $display("FAIL rst_sel_ready got %b required 0", key_sel_ready); end
        checks++; if (aes_key !== DEF_KEY || aes_keylen !== 1'b0) begin errors++; $display("FAIL rst_key got %h/%b required %h/0", aes_key, aes_keylen, DEF_KEY); end

        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd0, 16'd0));
        @(negedge clk);
        reset = 1'b0;
        init_n = 0; rdy_idx = -1; kr_idx = -1;
        for (int i = 0; i < 60 && kr_idx < 0; i++) begin
            @(negedge clk);
            #1;
            if (aes_init) init_n++;
            if (aes_ready && rdy_idx < 0) rdy_idx = i;
            if (key_ready && kr_idx < 0) kr_idx = i;
            if (i == 10) hold_low = 1'b0;
        end
        checks++; if (kr_idx < 0) begin errors++; $display("FAIL boot_key_ready_timeout got key_ready=0 required 1"); end
        checks++; if (init_n != 1) begin errors++; $display("FAIL boot_init_pulses got %0d required 1", init_n); end
        checks++; if (kr_idx != rdy_idx + 1) begin errors++; $display("FAIL boot_key_ready_cycle got %0d required %0d", kr_idx, rdy_idx + 1); end
        checks++; if (aes_key !== DEF_KEY) begin errors++; $display("FAIL boot_aes_key got %h required %h", aes_key, DEF_KEY); end
        checks++; if (enc_count !== 16'd0) begin errors++; $display("FAIL boot_enc_count got %0d required 0", enc_count); end
    endtask

    task automatic test_pending();
        logic found;
        next_cnt = 0;
        @(negedge clk);
        key_wr_valid = 1'b1; key_wr_slot = 2'd0; key_wr_data = DEF_KEY; key_wr_len = 1'b0;
        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd0, 16'd0));
        exp_q.push_back(mk_ev(1'b1, DEF_KEY, 1'b0, 2'd0, 16'd0));
        #1;
        checks++; if (key_wr_ready !== 1'b1) begin errors++; $display("FAIL pend_wr_ready got %b required 1", key_wr_ready); end
        @(negedge clk);
        key_wr_valid = 1'b0;
        #1;
        checks++; if (aes_init !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL pend_reinit got init=%b key_ready=%b required 1/0", aes_init, key_ready); end
        @(negedge clk); enc_start = 1'b1;
        @(negedge clk); enc_start = 1'b0;
        @(negedge clk); enc_start = 1'b1;
        @(negedge clk); enc_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (key_ready) begin
                found = 1'b1;
                checks++;
                if (aes_next !== 1'b1) begin errors++; $display("FAIL pend_next_first_ready got %b required 1", aes_next); end
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL pend_ready_timeout got key_ready=0 required 1"); end
        wait_idle("pend");
        checks++; if (next_cnt != 1) begin errors++; $display("FAIL pend_next_count got %0d required 1", next_cnt); end
        checks++; if (req_overrun !== 1'b1) begin errors++; $display("FAIL pend_overrun got %b required 1", req_overrun); end
        checks++; if (enc_count !== 16'd1) begin errors++; $display("FAIL pend_enc_count got %0d required 1", enc_count); end
    endtask

    task automatic test_key_sel();
        @(negedge clk);
        key_wr_valid = 1'b1; key_wr_slot = 2'd2; key_wr_data = K2; key_wr_len = 1'b1;
        #1;
        checks++; if (key_wr_ready !== 1'b1) begin errors++; $display("FAIL sel_wr2_ready got %b required 1", key_wr_ready); end
        @(negedge clk);
        key_wr_valid = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1 || active_slot !== 2'd0) begin errors++; $display("FAIL sel_wr2_noreinit got key_ready=%b slot=%0d required 1/0", key_ready, active_slot); end
        @(negedge clk);
        key_sel_valid = 1'b1; key_sel = 2'd2;
        exp_q.push_back(mk_ev(1'b0, K2, 1'b1, 2'd2, 16'd0));
        #1;
        checks++; if (key_sel_ready !== 1'b1) begin errors++; $display("FAIL sel_ready got %b required 1", key_sel_ready); end
        @(negedge clk);
        key_sel_valid = 1'b0;
        #1;
        checks++; if (active_slot !== 2'd2 || aes_key !== K2 || aes_keylen !== 1'b1) begin errors++; $display("FAIL sel_slot2 got slot=%0d key=%h len=%b required 2/%h/1", active_slot, aes_key, aes_keylen, K2); end
        checks++; if (aes_init !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL sel_init got init=%b key_ready=%b required 1/0", aes_init, key_ready); end
        wait_idle("sel");
        checks++; if (enc_count !== 16'd0) begin errors++; $display("FAIL sel_enc_count got %0d required 0", enc_count); end
        @(negedge clk);
        key_sel_valid = 1'b1; key_sel = 2'd2;
        #1;
        checks++; if (key_sel_ready !== 1'b1) begin errors++; $display("FAIL sel_same_ready got %b required 1", key_sel_ready); end
        @(negedge clk);
        key_sel_valid = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1 || aes_init !== 1'b0) begin errors++; $display("FAIL sel_same_noop got key_ready=%b init=%b required 1/0", key_ready, aes_init); end
    endtask

    task automatic test_write_during_enc();
        logic accepted;
        int blocked;
        @(negedge clk);
        exp_q.push_back(mk_ev(1'b1, K2, 1'b1, 2'd2, 16'd0));
        enc_start = 1'b1;
        key_wr_valid = 1'b1; key_wr_slot = 2'd2; key_wr_data = K3; key_wr_len = 1'b0;
        #1;
        checks++; if (aes_next !== 1'b1) begin errors++; $display("FAIL wr_enc_next got %b required 1", aes_next); end
        checks++; if (key_wr_ready !== 1'b0) begin errors++; $display("FAIL wr_same_cycle_ready got %b required 0", key_wr_ready); end
        @(negedge clk);
        enc_start = 1'b0;
        accepted = 1'b0; blocked = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (key_wr_ready) begin
                accepted = 1'b1;
                break;
            end
            blocked++;
            @(negedge clk);
        end
        checks++; if (!accepted) begin errors++; $display("FAIL wr_accept_timeout got key_wr_ready=0 required 1"); end
        checks++; if (blocked == 0) begin errors++; $display("FAIL wr_blocked_in_enc got %0d blocked cycles required >0", blocked); end
        checks++; if (key_sel_ready !== 1'b1 || enc_count !== 16'd1) begin errors++; $display("FAIL wr_accept_in_ready got sel_ready=%b cnt=%0d required 1/1", key_sel_ready, enc_count); end
        exp_q.push_back(mk_ev(1'b0, K3, 1'b0, 2'd2, 16'd0));
        @(negedge clk);
        key_wr_valid = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b0 || aes_key !== K3 || aes_keylen !== 1'b0) begin errors++; $display("FAIL wr_reinit got key_ready=%b key=%h len=%b required 0/%h/0", key_ready, aes_key, aes_keylen, K3); end
        wait_idle("wr");
        checks++; if (enc_count !== 16'd0) begin errors++; $display("FAIL wr_enc_count got %0d required 0", enc_count); end
    endtask

    task automatic test_rotation();
        logic found;
        @(negedge clk);
        key_sel_valid = 1'b1; key_sel = 2'd3;
        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd3, 16'd0));
        #1;
        checks++; if (key_sel_ready !== 1'b1) begin errors++; $display("FAIL rot_sel_ready got %b required 1", key_sel_ready); end
        @(negedge clk);
        key_sel_valid = 1'b0;
        wait_idle("rot_sel");
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_ev(1'b1, DEF_KEY, 1'b0, 2'd3, 16'(k)));
            if (k == 2) exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd0, 16'd0));
            @(negedge clk); enc_start = 1'b1;
            @(negedge clk); enc_start = 1'b0;
            if (k < 2) begin
                wait_idle("rot_enc");
                checks++; if (enc_count !== 16'(k + 1) || active_slot !== 2'd3) begin errors++; $display("FAIL rot_count_%0d got cnt=%0d slot=%0d required %0d/3", k, enc_count, active_slot, k + 1); end
            end
        end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (aes_init) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rot_init_timeout got aes_init=0 required 1"); end
        checks++; if (active_slot !== 2'd0 || key_ready !== 1'b0 || enc_count !== 16'd3) begin errors++; $display("FAIL rot_wrap got slot=%0d key_ready=%b cnt=%0d required 0/0/3", active_slot, key_ready, enc_count); end
        wait_idle("rot_exp");
        checks++; if (enc_count !== 16'd0 || active_slot !== 2'd0) begin errors++; $display("FAIL rot_after got cnt=%0d slot=%0d required 0/0", enc_count, active_slot); end
    endtask

    task automatic test_reset_during_enc();
        @(negedge clk);
        key_sel_valid = 1'b1; key_sel = 2'd1;
        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd1, 16'd0));
        @(negedge clk);
        key_sel_valid = 1'b0;
        wait_idle("mid_sel");
        exp_q.push_back(mk_ev(1'b1, DEF_KEY, 1'b0, 2'd1, 16'd0));
        @(negedge clk); enc_start = 1'b1;
        @(negedge clk); enc_start = 1'b0;
        wait_idle("mid_enc1");
        exp_q.push_back(mk_ev(1'b1, DEF_KEY, 1'b0, 2'd1, 16'd1));
        @(negedge clk); enc_start = 1'b1;
        @(negedge clk); enc_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (aes_next !== 1'b0 || aes_init !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses got next=%b init=%b required 0/0", aes_next, aes_init); end
        checks++; if (active_slot !== 2'd0 || enc_count !== 16'd0) begin errors++; $display("FAIL mid_rst_state got slot=%0d cnt=%0d required 0/0", active_slot, enc_count); end
        checks++; if (req_overrun !== 1'b0 || key_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got overrun=%b key_ready=%b required 0/0", req_overrun, key_ready); end
        repeat (2) @(negedge clk);
        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd0, 16'd0));
        reset = 1'b0;
        wait_idle("mid_boot");
        checks++; if (key_ready !== 1'b1 || active_slot !== 2'd0) begin errors++; $display("FAIL mid_reboot got key_ready=%b slot=%0d required 1/0", key_ready, active_slot); end
        @(negedge clk);
        key_sel_valid = 1'b1; key_sel = 2'd2;
        exp_q.push_back(mk_ev(1'b0, DEF_KEY, 1'b0, 2'd2, 16'd0));
        @(negedge clk);
        key_sel_valid = 1'b0;
        #1;
        checks++; if (aes_key !== DEF_KEY || aes_keylen !== 1'b0) begin errors++; $display("FAIL mid_slot2_default got %h/%b required %h/0", aes_key, aes_keylen, DEF_KEY); end
        wait_idle("mid_sel2");
    endtask

    initial begin
        test_reset();
        test_pending();
        test_key_sel();
        test_write_during_enc();
        test_rotation();
        test_reset_during_enc();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending events required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sequencer.md
Name: aes_key_sequencer

Overview:
- Parametrised key-management and sequencing controller that sits between the UART comm block and aes_core.
- Holds NUM_SLOTS runtime-writable AES keys and drives aes_core init/key/keylen.
- Gates encryption starts until key expansion completes, queuing one early request.
- Optionally rotates to the next key slot and re-expands after every REKEY_INTERVAL encryptions, as a side-channel countermeasure.

Parameters:
NUM_SLOTS, 4, number of key slots (>=1)
SLOT_W, $clog2(NUM_SLOTS) min 1, slot index width
DEFAULT_KEY, 256'h2b7e151628aed2a6abf7158809cf4f3c<<128, reset value of every slot
DEFAULT_KEYLEN, 1'b0, reset keylen of every slot (0=AES-128, 1=AES-256)
REKEY_INTERVAL, 0, encryptions per slot before rotation; 0 disables rotation
CNT_W, 16, width of encryption counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
key_wr_valid  in  1  key write request
key_wr_ready  out  1  key write accepted when valid&ready
key_wr_slot  in  SLOT_W  target slot
key_wr_data  in  256  key value (AES-128 uses [255:128])
key_wr_len  in  1  keylen for the slot
key_sel_valid  in  1  request to change active slot
key_sel_ready  out  1  slot change accepted when valid&ready
key_sel  in  SLOT_W  requested active slot
enc_start  in  1  single-cycle encryption request from comm
aes_ready  in  1  aes_core ready
aes_init  out  1  to aes_core init
aes_next  out  1  to aes_core next
aes_key  out  256  to aes_core key
aes_keylen  out  1  to aes_core keylen
key_ready  out  1  active key expanded; encryptions allowed
active_slot  out  SLOT_W  current slot
enc_count  out  CNT_W  encryptions on current slot; saturates
req_overrun  out  1  sticky: enc_start dropped

Behaviour:
- Reset (async, active-high): every slot = DEFAULT_KEY/DEFAULT_KEYLEN; active_slot=0; state=INIT; aes_init=0; aes_next=0; key_ready=0; enc_count=0; req_overrun=0; pending=0; key_wr_ready=0; key_sel_ready=0.
- aes_key and aes_keylen come combinationally from slot[active_slot]. They are stable outside READY because writes to the active slot are blocked there.
- States:
  - INIT: aes_init=1 for exactly one cycle, then go to EXPAND.
  - EXPAND: ignore aes_ready in the first cycle. Then wait for aes_ready=1, set key_ready=1 and enc_count=0, and go to READY.
  - READY: key_ready=1. Evaluated in priority order:
    1. pending or enc_start with aes_ready=1: aes_next=1 for one cycle, clear pending, go to ENC.
    2. Else accepted key_sel with key_sel != active_slot: load active_slot, key_ready=0, go to INIT. key_sel equal to active_slot is accepted as a no-op.
    3. Else accepted key write to the active slot: key_ready=0, go to INIT.
  - ENC: ignore aes_ready in the first cycle, then wait for aes_ready=1.
    - Increment enc_count (saturating).
    - If REKEY_INTERVAL!=0 and the new count == REKEY_INTERVAL: active_slot = (active_slot+1) mod NUM_SLOTS, key_ready=0, go to INIT.
    - Otherwise go to READY.
- enc_start outside READY, or in READY with aes_ready=0: sets pending (one deep). enc_start while pending=1 is dropped and sets req_overrun (cleared only by reset).
- key_wr_ready = 1 unless key_wr_slot == active_slot and state != READY. A write lands in the slot the cycle after acceptance.
- key_sel_ready = 1 only in READY with no pending and no enc_start that cycle. A simultaneous enc_start wins; key_sel is retried.
- A write to the active slot in the same READY cycle as enc_start is not accepted that cycle (key_wr_ready=0 whenever rule 1 fires).
- Rotation when NUM_SLOTS=1 re-expands the same slot.
- Reset mid-expansion or mid-encryption: all state is lost and expansion restarts from slot 0 with default keys.

Decomposition:
- Shared package aes_pkg:
  - state encoding constants ST_INIT, ST_EXPAND, ST_READY, ST_ENC
  - AES_KEY_W=256, AES_BLK_W=128
  - KEYLEN_128=0, KEYLEN_256=1
- Natural sub-module: aes_key_slot_ram, an NUM_SLOTS x 257-bit register file with one write port, one async read port and per-slot reset to defaults.
- The FSM stays in aes_key_sequencer.

Test Plan:
- Reset release, aes_core model holding ready low 10 cycles -> aes_init high exactly 1 cycle; key_ready rises the cycle after aes_ready returns; aes_key=2b7e1516...4f3c<<128.
- enc_start during EXPAND -> pending held; aes_next pulses once on the first READY cycle with aes_ready=1; second enc_start in EXPAND -> req_overrun=1 and still only one aes_next.
- Write slot2=000102..1f, keylen=1, then key_sel=2 in READY -> key_sel_ready=1, aes_init pulse, aes_keylen=1, aes_key=000102..1f, active_slot=2.
- Write to active slot during ENC -> key_wr_ready=0 until READY; accepted in READY -> re-INIT; enc_count back to 0.
- REKEY_INTERVAL=3, NUM_SLOTS=4, active=3, 3 encryptions -> third completion rotates active_slot to 0 with aes_init pulse; enc_count=0 after expansion.
- Assert reset during ENC -> aes_next/aes_init=0 immediately; active_slot=0; enc_count=0; req_overrun=0; new INIT after release.
